// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end.
// Owns the program counter, fetches 32-bit words over a req/ack handshake
// (ack returns data in the same cycle), buffers them in a DEPTH-entry FIFO
// and presents the FIFO head on ibus, or a NOP when nothing is buffered.
// All vectors use CPU bus ordering: bit 0 is the MSB.
module ifetch_unit #(
    parameter logic [0:31] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic        imem_ack,
    input  logic [0:31] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [0:31] redirect_pc,
    output logic [0:31] ibus,
    output logic        ibus_valid
);

    // Pointer width covers DEPTH entries (DEPTH is a power of two, so the
    // pointers wrap naturally); the count needs one extra value for "full".
    localparam int              PW       = $clog2(DEPTH);
    localparam int              CW       = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [PW-1:0]   PTR_ZERO = PW'(0);
    localparam logic [PW-1:0]   PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_DISCARD = 2'b10
    } state_t;

    // Fetch control registers
    state_t        state_r;
    logic [0:31]   pc_r;
    logic          imem_req_r;
    logic [0:31]   imem_addr_r;

    // Instruction buffer registers
    logic [0:31]   fifo_mem_r [0:DEPTH-1];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;
    logic [0:31]   ibus_r;
    logic          ibus_valid_r;

    // Next-state helpers
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] remain_s;
    logic [CW-1:0] count_next_s;
    logic [PW-1:0] rd_ptr_next_s;
    logic [PW-1:0] wr_ptr_next_s;
    logic [0:31]   head_next_s;
    logic          head_valid_next_s;
    logic [0:31]   redirect_tgt_s;
    logic [0:31]   pc_inc_s;

    // Redirect targets are always word aligned; the low two bits are dropped.
    assign redirect_tgt_s = redirect_pc & 32'hFFFF_FFFC;
    // PC increment wraps modulo 2^32 without any flag.
    assign pc_inc_s       = pc_r + 32'd4;

    // Only a live fetch (not a discarded one) delivers data; redirect kills
    // both the push and the pop of the cycle it is sampled in.
    assign push_s = (state_r == ST_REQ) && imem_ack && !redirect;
    assign pop_s  = ibus_valid_r && !stall && !redirect;

    // FIFO bookkeeping: next count, pointers and the value of the next head
    always_comb begin
        remain_s          = count_r;
        count_next_s      = count_r;
        rd_ptr_next_s     = rd_ptr_r;
        wr_ptr_next_s     = wr_ptr_r;
        head_next_s       = 32'h0000_0000;
        head_valid_next_s = 1'b0;

        if (pop_s) begin
            remain_s      = count_r - CNT_ONE;
            rd_ptr_next_s = rd_ptr_r + PTR_ONE;
        end else begin
            remain_s      = count_r;
            rd_ptr_next_s = rd_ptr_r;
        end

        if (push_s) begin
            count_next_s  = remain_s + CNT_ONE;
            wr_ptr_next_s = wr_ptr_r + PTR_ONE;
        end else begin
            count_next_s  = remain_s;
            wr_ptr_next_s = wr_ptr_r;
        end

        if (redirect) begin
            count_next_s  = CNT_ZERO;
            rd_ptr_next_s = PTR_ZERO;
            wr_ptr_next_s = PTR_ZERO;
        end else begin
            count_next_s  = count_next_s;
        end

        // The head after this edge is either an older buffered word or, when
        // nothing older survives the pop, the word being written right now.
        if (count_next_s == CNT_ZERO) begin
            head_next_s       = 32'h0000_0000;
            head_valid_next_s = 1'b0;
        end else if (remain_s == CNT_ZERO) begin
            head_next_s       = imem_rdata;
            head_valid_next_s = 1'b1;
        end else begin
            head_next_s       = fifo_mem_r[rd_ptr_next_s];
            head_valid_next_s = 1'b1;
        end
    end

    // Fetch FSM: owns pc and the registered memory request/address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_PC;
            imem_req_r  <= 1'b0;
            imem_addr_r <= RESET_PC;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (redirect) begin
                        // Fetching restarts from the new pc on the next edge.
                        pc_r <= redirect_tgt_s;
                    end else if (count_r < DEPTH_C) begin
                        state_r     <= ST_REQ;
                        imem_req_r  <= 1'b1;
                        imem_addr_r <= pc_r;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (redirect) begin
                        pc_r <= redirect_tgt_s;
                        if (imem_ack) begin
                            // Data in the redirect cycle is dropped.
                            state_r    <= ST_IDLE;
                            imem_req_r <= 1'b0;
                        end else begin
                            // Requests are never withdrawn: keep the stale
                            // address up and throw its data away later.
                            state_r <= ST_DISCARD;
                        end
                    end else if (imem_ack) begin
                        pc_r <= pc_inc_s;
                        if (count_next_s < DEPTH_C) begin
                            imem_addr_r <= pc_inc_s;
                        end else begin
                            state_r    <= ST_IDLE;
                            imem_req_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_DISCARD: begin
                    if (redirect) begin
                        pc_r <= redirect_tgt_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                    if (imem_ack) begin
                        state_r    <= ST_IDLE;
                        imem_req_r <= 1'b0;
                    end else begin
                        state_r <= ST_DISCARD;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    imem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Instruction buffer and registered head presented to decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_r[i] <= 32'h0000_0000;
            end
            rd_ptr_r     <= PTR_ZERO;
            wr_ptr_r     <= PTR_ZERO;
            count_r      <= CNT_ZERO;
            ibus_r       <= 32'h0000_0000;
            ibus_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= imem_rdata;
            end
            rd_ptr_r     <= rd_ptr_next_s;
            wr_ptr_r     <= wr_ptr_next_s;
            count_r      <= count_next_s;
            ibus_r       <= head_next_s;
            ibus_valid_r <= head_valid_next_s;
        end
    end

    assign imem_req   = imem_req_r;
    assign imem_addr  = imem_addr_r;
    assign ibus       = ibus_r;
    assign ibus_valid = ibus_valid_r;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench for ifetch_unit.
// A driver issues memory responses, stalls and redirects; a reference model
// tracks the expected fetch pc and the expected instruction stream as a queue;
// a monitor compares ibus/imem outputs against the queue every cycle.
module tb_ifetch_unit;

    localparam logic [0:31] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [0:31] imem_addr;
    logic        imem_ack = 1'b0;
    logic [0:31] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [0:31] redirect_pc = 32'h0;
    logic [0:31] ibus;
    logic        ibus_valid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [0:31] exp_q [$];
    logic [0:31] exp_pc = RST_PC;
    logic        drop_pending = 1'b0;
    logic        last_redir = 1'b0;
    int          n_push = 0;
    int          idle_run = 0;

    // Snapshot of the cycle's inputs/outputs taken at the falling edge
    logic        s_req = 1'b0, s_ack = 1'b0, s_valid = 1'b0, s_stall = 1'b0, s_redir = 1'b0;
    logic [0:31] s_addr = 32'h0, s_rpc = 32'h0;
    logic        skip_stab = 1'b1;
    int          wcnt = 0;

    ifetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ibus(ibus), .ibus_valid(ibus_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [0:31] mem_word(input logic [0:31] a);
        return a ^ 32'h3C5A_96E1;
    endfunction

    task automatic check(input string name, input logic [0:31] act, input logic [0:31] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: fetch pc and expected instruction queue, per rising edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_pc       <= RST_PC;
            drop_pending <= 1'b0;
            last_redir   <= 1'b0;
        end else begin
            last_redir <= s_redir;
            if (s_redir) begin
                exp_q.delete();
                exp_pc <= s_rpc & 32'hFFFF_FFFC;
                if (s_req && s_ack) drop_pending <= 1'b0;
                else if (s_req) drop_pending <= 1'b1;
            end else begin
                if (s_valid && !s_stall && exp_q.size() != 0) void'(exp_q.pop_front());
                if (s_req && s_ack) begin
                    if (drop_pending) begin
                        drop_pending <= 1'b0;
                    end else begin
                        check("fetch_addr", s_addr, exp_pc);
                        exp_q.push_back(mem_word(exp_pc));
                        exp_pc <= exp_pc + 32'd4;
                        n_push <= n_push + 1;
                    end
                end
            end
        end
    end

    // Monitor: compare presented outputs against the model each cycle
    always @(negedge clk) begin
        int nr;
        if (rst_n) begin
            check("ibus_valid", ibus_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) check("ibus_word", ibus, exp_q[0]);
            else                   check("ibus_nop", ibus, 32'h0);
            check("fifo_bound", exp_q.size() <= DEPTH, 1'b1);
            if (exp_q.size() == DEPTH) check("req_when_full", imem_req, 1'b0);
            if (imem_req && !drop_pending) check("req_addr", imem_addr, exp_pc);
            nr = (!imem_req && exp_q.size() < DEPTH && !last_redir) ? idle_run + 1 : 0;
            check("idle_gap", nr <= 1, 1'b1);
            idle_run <= nr;
        end else begin
            idle_run <= 0;
        end
    end

    // One driver cycle. mode: 0 zero-wait, 1 ack after 3 waits, 2 random, 3 no ack
    task automatic step(input int mode, input logic st, input logic rd, input logic [0:31] rpc);
        @(negedge clk);
        if (!skip_stab && s_req && !s_ack) begin
            check("req_hold", imem_req, 1'b1);
            check("addr_hold", imem_addr, s_addr);
        end
        case (mode)
            0: imem_ack = 1'b1;
            1: begin
                if (imem_req) begin
                    imem_ack = (wcnt >= 3);
                    wcnt = imem_ack ? 0 : wcnt + 1;
                end else begin
                    imem_ack = 1'b0;
                    wcnt = 0;
                end
            end
            2: imem_ack = 1'($urandom_range(0, 1));
            default: imem_ack = 1'b0;
        endcase
        imem_rdata  = imem_req ? mem_word(imem_addr) : 32'($urandom);
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        s_req = imem_req; s_addr = imem_addr; s_ack = imem_ack;
        s_valid = ibus_valid; s_stall = st; s_redir = rd; s_rpc = rpc;
        skip_stab = 1'b0;
    endtask

    // Asynchronous reset pulse mid-cycle, then restart checks
    task automatic pulse_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        redirect = 1'b0; stall = 1'b0; imem_ack = 1'b0;
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RST_PC);
        check("rst_ibus", ibus, 32'h0);
        check("rst_valid", ibus_valid, 1'b0);
        s_req = 1'b0; s_ack = 1'b0; s_valid = 1'b0; s_stall = 1'b0; s_redir = 1'b0;
        skip_stab = 1'b1;
        wcnt = 0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        step(3, 1'b0, 1'b0, 32'h0);
        check("restart_req", imem_req, 1'b1);
        check("restart_addr", imem_addr, RST_PC);
    endtask

    initial begin
        logic [0:31] rpc;
        pulse_reset();

        // Zero-wait streaming, wrapping FFFFFFF8 -> FFFFFFFC -> 00000000
        repeat (20) step(0, 1'b0, 1'b0, 32'h0);

        // Slow memory with a reset while a request waits
        repeat (10) step(1, 1'b0, 1'b0, 32'h0);
        pulse_reset();
        repeat (30) step(1, 1'b0, 1'b0, 32'h0);

        // Stall fills the buffer, reset with it full, then stall again and release
        repeat (4) step(0, 1'b0, 1'b0, 32'h0);
        repeat (4) step(0, 1'b1, 1'b0, 32'h0);
        pulse_reset();
        repeat (4) step(0, 1'b0, 1'b0, 32'h0);
        repeat (4) step(0, 1'b1, 1'b0, 32'h0);
        repeat (10) step(0, 1'b0, 1'b0, 32'h0);

        // Redirect to 0x1003 while a request waits; its ack comes 2 cycles later
        for (int i = 0; i < 20 && !(imem_req && !drop_pending); i++) step(3, 1'b0, 1'b0, 32'h0);
        check("redir_setup", imem_req, 1'b1);
        step(3, 1'b0, 1'b1, 32'h0000_1003);
        step(3, 1'b0, 1'b0, 32'h0);
        step(0, 1'b0, 1'b0, 32'h0);
        repeat (20) step(0, 1'b0, 1'b0, 32'h0);

        // Randomised traffic with occasional reset
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) pulse_reset();
            rpc = 32'($urandom);
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'h0000_000F);
            step(2, ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0), rpc);
        end
        repeat (4) step(0, 1'b0, 1'b0, 32'h0);

        check("progress", n_push > 100, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch front end for the 4-stage pipelined CPU.
- Owns the program counter and fetches 32-bit words from instruction memory using a req/ack handshake.
- Buffers the fetched words in a small FIFO and presents one instruction per cycle on ibus, which feeds the CPU decode stage.
- Inserts NOP (32'h00000000) when no instruction is available, and supports stall and PC redirect.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset; bits [30:31] must be 00.
- DEPTH, 2, instruction FIFO entries; legal values 2 or 4.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  [0:31]  byte address of the requested word; bits [30:31] always 00.
- imem_ack  in  1  memory accepts the request and returns imem_rdata in the same cycle.
- imem_rdata  in  [0:31]  fetched instruction word; sampled only when imem_req && imem_ack.
- stall  in  1  pipeline hold; when 1, ibus must not advance.
- redirect  in  1  load a new PC and flush the buffered instructions.
- redirect_pc  in  [0:31]  target PC; bits [30:31] are ignored and forced to 00.
- ibus  out  [0:31]  instruction to decode: the FIFO head, or 32'h00000000 when the FIFO is empty.
- ibus_valid  out  1  1 when ibus holds a fetched instruction rather than a filler NOP.

Behaviour:
- Bit 0 is the MSB on all vectors, matching CPU bus ordering.
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, state=IDLE, FIFO empty, count=0.
  - imem_req=0, imem_addr=RESET_PC.
  - ibus=32'h0, ibus_valid=0.
- The first imem_req assertion occurs on the first rising edge after rst_n deasserts.
- States:
  - IDLE: no request outstanding.
  - REQ: imem_req=1, imem_addr=pc.
  - DISCARD: imem_req=1 on a stale address; its response will be dropped.
- IDLE -> REQ when count < DEPTH and redirect=0.
- REQ, on imem_ack with no redirect:
  - Push imem_rdata and set pc <= pc+4.
  - Stay in REQ if the post-update count < DEPTH, otherwise go to IDLE.
  - Back-to-back fetches are permitted, giving 1 word/cycle with zero-wait memory.
- Handshake rules:
  - Once imem_req=1, it and imem_addr stay stable until the cycle imem_ack=1.
  - Requests are never withdrawn, including on redirect.
  - imem_ack while imem_req=0 is ignored.
- Space check: count includes the outstanding request, so the FIFO can never overflow. A push and a pop in the same cycle leave count unchanged.
- Output side:
  - ibus and ibus_valid are driven from FIFO head registers, with no combinational path from imem_rdata.
  - Latency: imem_ack at edge N with an empty FIFO gives ibus valid after edge N (visible in cycle N+1).
  - Pop occurs at an edge where ibus_valid=1 and stall=0.
  - When stall=1, ibus holds its value.
  - When empty, ibus=0 and ibus_valid=0; stall has no effect.
- Redirect (sampled at the rising edge; highest priority):
  - The FIFO is flushed and ibus_valid=0 on the following cycle.
  - A pop or push in that same cycle is discarded.
  - pc <= {redirect_pc[0:29],2'b00}.
  - If in REQ with imem_ack=0: go to DISCARD and keep the old imem_addr. On the next imem_ack, drop the data and go to IDLE; a request for the new pc follows on the next edge.
  - If in REQ with imem_ack=1 in the redirect cycle: drop the data and go to IDLE.
  - If in DISCARD: a further redirect updates pc only and the state stays DISCARD.
  - Redirect while IDLE: pc updates and fetching restarts on the following edge.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 wraps to 32'h00000000, with no flag.
- Reset mid-transaction: asynchronous return to reset values. The outstanding request is abandoned, and memory must tolerate imem_req dropping.
- FIFO pointers wrap modulo DEPTH. Full is count==DEPTH; empty is count==0.

Test Plan:
- Reset, then zero-wait memory with imem_ack tied 1 and rdata = addr-based pattern → imem_addr sequence 0,4,8,C…; ibus shows word@0 one cycle after the first ack, then one new word per cycle; ibus_valid stays 1.
- imem_ack delayed 3 cycles per request → imem_addr stable for the whole wait; ibus=0 and ibus_valid=0 in gap cycles; no word lost or duplicated.
- stall=1 for 4 cycles with DEPTH=2 → FIFO fills; imem_req drops after 2 buffered words; ibus holds word@8; on release, words @8 and @C then @10 appear in order.
- redirect with redirect_pc=32'h00001003 while a request to 0x10 is pending (ack 2 cycles later) → 0x10 data dropped; next imem_addr=32'h00001000; ibus_valid=0 until word@1000 arrives.
- RESET_PC=32'hFFFFFFF8, zero-wait memory → imem_addr sequence FFFFFFF8, FFFFFFFC, 00000000.
- rst_n pulsed low during a pending request and with 2 words buffered → outputs return to reset values immediately; fetch restarts at RESET_PC.
